// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Instruction-sequencing FSM for the 8-bit processor. Runs each
//            instruction as fetch (F0..F2), decode (D), then an opcode-specific
//            execute sequence, driving all datapath strobes Moore-style from
//            the current state and the latched IR.
// Options  : CU_BRANCH_COND_EN - when defined, conditional branches 21..28
//            evaluate their CCR flag; otherwise they are never taken.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] BUS1_Sel,
    output logic [1:0] BUS2_Sel,
    output logic       write
);

    typedef enum logic [3:0] {
        S_F0  = 4'd0,
        S_F1  = 4'd1,
        S_F2  = 4'd2,
        S_D   = 4'd3,
        S_E0  = 4'd4,
        S_E1  = 4'd5,
        S_E2  = 4'd6,
        S_E3  = 4'd7,
        S_E4  = 4'd8,
        S_BNT = 4'd9
    } state_t;

    localparam logic [1:0] c_BUS1_PC  = 2'b00;
    localparam logic [1:0] c_BUS1_A   = 2'b01;
    localparam logic [1:0] c_BUS1_B   = 2'b10;
    localparam logic [1:0] c_BUS2_ALU = 2'b00;
    localparam logic [1:0] c_BUS2_B1  = 2'b01;
    localparam logic [1:0] c_BUS2_MEM = 2'b10;

    state_t r_state;
    state_t w_next;

    logic   w_ld_imm;
    logic   w_ld_dir;
    logic   w_store;
    logic   w_alu;
    logic   w_branch;
    logic   w_to_b;
    logic   w_cond;
    logic   w_taken;

    // Opcode classes; the execute states reuse these since IR is stable
    // from F2 until the next fetch.
    assign w_ld_imm = (IR == 8'h86) || (IR == 8'h88);
    assign w_ld_dir = (IR == 8'h87) || (IR == 8'h89);
    assign w_store  = (IR == 8'h96) || (IR == 8'h97);
    assign w_alu    = (IR >= 8'h42) && (IR <= 8'h47);
    assign w_branch = (IR >= 8'h20) && (IR <= 8'h28);
    assign w_to_b   = (IR == 8'h88) || (IR == 8'h89) || (IR == 8'h97);

`ifdef CU_BRANCH_COND_EN
    // Flag test for conditional branches, CCR_Result = {N,Z,V,C}.
    always_comb begin
        w_cond = 1'b0;
        case (IR)
            8'h21:   w_cond =  CCR_Result[3];
            8'h22:   w_cond = ~CCR_Result[3];
            8'h23:   w_cond =  CCR_Result[2];
            8'h24:   w_cond = ~CCR_Result[2];
            8'h25:   w_cond =  CCR_Result[1];
            8'h26:   w_cond = ~CCR_Result[1];
            8'h27:   w_cond =  CCR_Result[0];
            8'h28:   w_cond = ~CCR_Result[0];
            default: w_cond = 1'b0;
        endcase
    end
`else
    // Without condition evaluation every conditional branch falls through.
    logic w_unused_ccr;
    assign w_unused_ccr = ^CCR_Result;
    assign w_cond       = 1'b0;
`endif

    assign w_taken = (IR == 8'h20) || w_cond;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_F0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and Moore strobe decode (all quiet during reset).
    always_comb begin
        w_next   = S_F0;
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        CCR_Load = 1'b0;
        ALU_Sel  = 3'b000;
        BUS1_Sel = c_BUS1_PC;
        BUS2_Sel = c_BUS2_ALU;
        write    = 1'b0;

        case (r_state)
            S_F0:  w_next = S_F1;
            S_F1:  w_next = S_F2;
            S_F2:  w_next = S_D;
            S_D: begin
                if (w_ld_imm || w_ld_dir || w_store || w_alu) begin
                    w_next = S_E0;
                end else if (w_branch) begin
                    w_next = w_taken ? S_E0 : S_BNT;
                end else begin
                    w_next = S_F0;
                end
            end
            S_E0:  w_next = w_alu ? S_F0 : S_E1;
            S_E1:  w_next = S_E2;
            S_E2:  w_next = (w_ld_imm || w_branch) ? S_F0 : S_E3;
            S_E3:  w_next = w_store ? S_F0 : S_E4;
            default: w_next = S_F0;
        endcase

        if (rst) begin
            case (r_state)
                S_F0: begin
                    BUS2_Sel = c_BUS2_B1;
                    MAR_Load = 1'b1;
                end
                S_F1:  PC_Inc = 1'b1;
                S_F2: begin
                    BUS2_Sel = c_BUS2_MEM;
                    IR_Load  = 1'b1;
                end
                S_E0: begin
                    if (w_alu) begin
                        BUS1_Sel = c_BUS1_A;
                        ALU_Sel  = IR[2:0] - 3'd2;
                        A_Load   = 1'b1;
                        CCR_Load = 1'b1;
                    end else begin
                        BUS2_Sel = c_BUS2_B1;
                        MAR_Load = 1'b1;
                    end
                end
                // Branches only wait here; loads and stores step past the operand.
                S_E1:  PC_Inc = ~w_branch;
                S_E2: begin
                    BUS2_Sel = c_BUS2_MEM;
                    if (w_ld_imm) begin
                        A_Load = ~w_to_b;
                        B_Load =  w_to_b;
                    end else if (w_branch) begin
                        PC_Load = 1'b1;
                    end else begin
                        MAR_Load = 1'b1;
                    end
                end
                S_E3: begin
                    if (w_store) begin
                        BUS1_Sel = w_to_b ? c_BUS1_B : c_BUS1_A;
                        write    = 1'b1;
                    end
                end
                S_E4: begin
                    BUS2_Sel = c_BUS2_MEM;
                    A_Load   = ~w_to_b;
                    B_Load   =  w_to_b;
                end
                S_BNT: PC_Inc = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Bench for control_unit. A small datapath/memory environment is
//            driven by the DUT strobes; an instruction-level reference model
//            predicts registers, cycle counts and strobe counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] BUS1_Sel, BUS2_Sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst), .IR(IR), .CCR_Result(CCR_Result),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
        .BUS1_Sel(BUS1_Sel), .BUS2_Sel(BUS2_Sel), .write(write)
    );

    localparam logic [14:0] c_F0_SIG = 15'b0100000_000_00_01_0;
    logic [14:0] outs;
    assign outs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                   ALU_Sel, BUS1_Sel, BUS2_Sel, write};

    // ---------------- datapath environment ----------------
    logic [7:0] mem  [256];
    logic [7:0] prog [256];
    logic [7:0] pc, mar, a, b;
    logic [7:0] pre_pc, pre_a, pre_b, pre_ir;
    logic [3:0] pre_ccr;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] bus1, bus2;
    logic [11:0] alu_out;

    // ALU shared by the environment and the model: returns {N,Z,V,C,result}.
    function automatic logic [11:0] alu_fn(input logic [2:0] sel, input logic [7:0] x,
                                           input logic [7:0] y);
        logic [8:0] s;
        logic [7:0] r;
        logic       v, c;
        v = 1'b0; c = 1'b0; r = x;
        case (sel)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8];
                        v = (x[7] == y[7]) && (r[7] != x[7]); end
            3'd1: begin r = x - y; c = (x < y); v = (x[7] != y[7]) && (r[7] != x[7]); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: begin r = x + 8'd1; c = (x == 8'hFF); v = (x == 8'h7F); end
            3'd5: begin r = x - 8'd1; c = (x == 8'h00); v = (x == 8'h80); end
            default: r = x;
        endcase
        return {r[7], (r == 8'h00), v, c, r};
    endfunction

    always_comb begin
        case (BUS1_Sel)
            2'b01:   bus1 = a;
            2'b10:   bus1 = b;
            default: bus1 = pc;
        endcase
        alu_out = alu_fn(ALU_Sel, bus1, b);
        case (BUS2_Sel)
            2'b00:   bus2 = alu_out[7:0];
            2'b01:   bus2 = bus1;
            default: bus2 = mem[mar];
        endcase
    end

    always @(posedge clk) begin
        if (!rst) begin
            pc <= pre_pc; a <= pre_a; b <= pre_b; IR <= pre_ir;
            CCR_Result <= pre_ccr; mar <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else begin
            if (IR_Load)  IR <= bus2;
            if (MAR_Load) mar <= bus2;
            if (PC_Load)       pc <= bus2;
            else if (PC_Inc)   pc <= pc + 8'd1;
            if (A_Load)   a <= bus2;
            if (B_Load)   b <= bus2;
            if (CCR_Load) CCR_Result <= alu_out[11:8];
            if (write) begin
                mem[mar] <= bus1; wr_addr <= mar; wr_data <= bus1;
            end
        end
    end

    // ---------------- instruction-level reference model ----------------
    logic [7:0] m_pc, m_a, m_b;
    logic [3:0] m_ccr;
    logic [7:0] m_mem [256];

    function automatic bit taken_fn(input logic [7:0] op, input logic [3:0] ccr);
        int idx;
        bit want;
        if (op == 8'h20) return 1'b1;
`ifdef CU_BRANCH_COND_EN
        idx  = (int'(op) - 8'h21) / 2;        // 0:N 1:Z 2:V 3:C
        want = ((int'(op) - 8'h21) % 2) == 0; // odd opcodes test for set
        return ccr[3 - idx] == want;
`else
        idx = 0; want = ccr[0];
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        m_pc = pre_pc; m_a = pre_a; m_b = pre_b; m_ccr = pre_ccr;
        for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
    endtask

    task automatic init_test();
        rst = 1'b0;
        tick(); tick();
        model_init();
        rst = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        pre_pc = 8'h00; pre_a = 8'h00; pre_b = 8'h00; pre_ccr = 4'h0; pre_ir = 8'h00;
    endtask

    // Execute one instruction on DUT and model, then compare.
    task automatic run_instr(input string name);
        logic [7:0] op, opnd, e_waddr, e_wdata;
        logic [2:0] asel;
        int cyc, e_inc, e_pcl, e_wr, e_ab;
        int n_inc, n_pcl, n_wr, n_irl, n_ab, n_alu, n_viol, wr_at;
        bit is_alu;
        op = m_mem[m_pc]; opnd = m_mem[m_pc + 8'd1];
        e_wr = 0; e_pcl = 0; e_inc = 2; e_ab = 0; is_alu = 0; asel = 3'd0;
        e_waddr = 8'h00; e_wdata = 8'h00;
        if (op == 8'h86 || op == 8'h88) begin
            if (op == 8'h86) m_a = opnd; else m_b = opnd;
            m_pc += 8'd2; cyc = 7; e_ab = 1;
        end else if (op == 8'h87 || op == 8'h89) begin
            if (op == 8'h87) m_a = m_mem[opnd]; else m_b = m_mem[opnd];
            m_pc += 8'd2; cyc = 9; e_ab = 1;
        end else if (op == 8'h96 || op == 8'h97) begin
            e_waddr = opnd; e_wdata = (op == 8'h96) ? m_a : m_b;
            m_mem[opnd] = e_wdata; m_pc += 8'd2; cyc = 8; e_wr = 1;
        end else if (op inside {[8'h42:8'h47]}) begin
            asel = 3'(op - 8'h42);
            {m_ccr, m_a} = alu_fn(asel, m_a, m_b);
            m_pc += 8'd1; cyc = 5; e_inc = 1; e_ab = 1; is_alu = 1;
        end else if (op inside {[8'h20:8'h28]}) begin
            if (taken_fn(op, m_ccr)) begin
                m_pc = opnd; cyc = 7; e_inc = 1; e_pcl = 1;
            end else begin
                m_pc += 8'd2; cyc = 5;
            end
        end else begin
            m_pc += 8'd1; cyc = 4; e_inc = 1;
        end

        n_inc = 0; n_pcl = 0; n_wr = 0; n_irl = 0; n_ab = 0; n_alu = 0; n_viol = 0; wr_at = -1;
        for (int k = 0; k < cyc; k++) begin
            if (PC_Inc)  n_inc++;
            if (PC_Load) n_pcl++;
            if (write) begin n_wr++; wr_at = k; end
            if (IR_Load) n_irl++;
            if (A_Load || B_Load) n_ab++;
            if (is_alu && A_Load && CCR_Load && BUS1_Sel == 2'b01 && BUS2_Sel == 2'b00
                && ALU_Sel == asel) n_alu++;
            if (!is_alu && CCR_Load) n_viol++;
            if (write && (IR_Load || MAR_Load || PC_Load || A_Load || B_Load || CCR_Load)) n_viol++;
            if (PC_Load && PC_Inc) n_viol++;
            tick();
        end

        n_tests++;
        if ({pc, a, b, CCR_Result} !== {m_pc, m_a, m_b, m_ccr}) begin
            n_fail++;
            $display("FAIL %s op=%h regs pc/a/b/ccr: got %h/%h/%h/%h want %h/%h/%h/%h", name, op,
                     pc, a, b, CCR_Result, m_pc, m_a, m_b, m_ccr);
        end
        n_tests++;
        if ({n_inc, n_pcl, n_wr, n_irl, n_ab} !== {e_inc, e_pcl, e_wr, 32'd1, e_ab}) begin
            n_fail++;
            $display("FAIL %s op=%h strobe counts inc/pcl/wr/irl/ab: got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/1/%0d",
                     name, op, n_inc, n_pcl, n_wr, n_irl, n_ab, e_inc, e_pcl, e_wr, e_ab);
        end
        n_tests++;
        if (n_viol !== 0) begin
            n_fail++;
            $display("FAIL %s op=%h strobe conflicts: got %0d want 0", name, op, n_viol);
        end
        n_tests++;
        if (outs !== c_F0_SIG) begin
            n_fail++;
            $display("FAIL %s op=%h next fetch after %0d cycles: got outs=%b want %b",
                     name, op, cyc, outs, c_F0_SIG);
        end
        if (is_alu) begin
            n_tests++;
            if (n_alu !== 1) begin
                n_fail++;
                $display("FAIL %s op=%h alu cycle: got %0d want 1", name, op, n_alu);
            end
        end
        if (e_wr == 1) begin
            n_tests++;
            if ({wr_at, wr_addr, wr_data} !== {cyc - 1, e_waddr, e_wdata}) begin
                n_fail++;
                $display("FAIL %s op=%h write cycle/addr/data: got %0d/%h/%h want %0d/%h/%h",
                         name, op, wr_at, wr_addr, wr_data, cyc - 1, e_waddr, e_wdata);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_prog();
        pre_ir = 8'h86;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (outs !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0", k, outs);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (outs !== c_F0_SIG) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", outs, c_F0_SIG);
        end
    endtask

    task automatic test_lda_imm();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'h5A;
        init_test();
        run_instr("lda_imm");
        n_tests++;
        if ({a, pc} !== 16'h5A02) begin
            n_fail++;
            $display("FAIL lda_imm_const a/pc: got %h/%h want 5a/02", a, pc);
        end
    endtask

    task automatic test_sta_dir();
        clear_prog();
        prog[0] = 8'h86; prog[1] = 8'h3C; prog[2] = 8'h96; prog[3] = 8'h80;
        init_test();
        run_instr("sta_pre_lda");
        run_instr("sta_dir");
        n_tests++;
        if ({wr_addr, wr_data, mem[8'h80]} !== 24'h803C3C) begin
            n_fail++;
            $display("FAIL sta_const addr/data/mem: got %h/%h/%h want 80/3c/3c",
                     wr_addr, wr_data, mem[8'h80]);
        end
    endtask

    task automatic test_add_ab();
        clear_prog();
        prog[0] = 8'h42; pre_a = 8'h7F; pre_b = 8'h01;
        init_test();
        run_instr("add_ab");
        n_tests++;
        if ({a, CCR_Result[3], CCR_Result[1]} !== {8'h80, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL add_const a/N/V: got %h/%b/%b want 80/1/1", a, CCR_Result[3], CCR_Result[1]);
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_pc;
        clear_prog();
        prog[0] = 8'h23; prog[1] = 8'h40; pre_ccr = 4'b0100;
        init_test();
        run_instr("beq_z1");
`ifdef CU_BRANCH_COND_EN
        exp_pc = 8'h40;
`else
        exp_pc = 8'h02;
`endif
        n_tests++;
        if (pc !== exp_pc) begin
            n_fail++;
            $display("FAIL beq_z1_pc: got %h want %h", pc, exp_pc);
        end
        pre_ccr = 4'b0000;
        init_test();
        run_instr("beq_z0");
        n_tests++;
        if (pc !== 8'h02) begin
            n_fail++;
            $display("FAIL beq_z0_pc: got %h want 02", pc);
        end
        prog[0] = 8'h20; prog[1] = 8'hC5;
        init_test();
        run_instr("bra");
    endtask

    task automatic test_reset_mid();
        int n_aload;
        clear_prog();
        prog[0] = 8'h87; prog[1] = 8'h10; prog[8'h10] = 8'h77;
        init_test();
        n_aload = 0;
        for (int k = 0; k < 7; k++) begin
            if (A_Load) n_aload++;
            tick();
        end
        rst = 1'b0;           // now in E3 of the direct load
        #1;
        if (A_Load) n_aload++;
        tick();
        if (A_Load) n_aload++;
        n_tests++;
        if ({outs, a, n_aload} !== {15'd0, 8'h00, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid outs/a/aload: got %b/%h/%0d want 0/00/0", outs, a, n_aload);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (outs !== c_F0_SIG) begin
            n_fail++;
            $display("FAIL reset_mid_refetch: got %b want %b", outs, c_F0_SIG);
        end
        model_init();
        run_instr("lda_dir_after_reset");
        // undefined opcode followed by an immediate load
        clear_prog();
        prog[0] = 8'hFF; prog[1] = 8'h86; prog[2] = 8'h11;
        init_test();
        run_instr("nop_ff");
        run_instr("lda_after_nop");
    endtask

    task automatic test_random();
        logic [7:0] ops [24] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
                                 8'h44, 8'h45, 8'h46, 8'h47, 8'h20, 8'h21, 8'h22, 8'h23,
                                 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'hFF, 8'h00, 8'h42};
        int mem_bad;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++)
                prog[i] = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 23)]
                                                      : 8'($urandom);
            pre_pc = 8'($urandom); pre_a = 8'($urandom); pre_b = 8'($urandom);
            pre_ccr = 4'($urandom); pre_ir = 8'h00;
            init_test();
            for (int n = 0; n < 40; n++) run_instr("random");
            mem_bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) mem_bad++;
            n_tests++;
            if (mem_bad != 0) begin
                n_fail++;
                $display("FAIL random_memory round %0d: got %0d differing bytes want 0", r, mem_bad);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_prog();
        test_reset();
        test_lda_imm();
        test_sta_dir();
        test_add_ab();
        test_branch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
